// File: rtl/elevator_call_scheduler_pkg.sv
// Shared types and constants for the elevator call scheduler.
package elevator_call_scheduler_pkg;

  // Default width of floor numbers.
  localparam int FLOOR_W = 4;

  // Scheduler FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_DWELL      = 2'b01,
    ST_SERVE_UP   = 2'b10,
    ST_SERVE_DOWN = 2'b11
  } ecs_state_e;

  // Width of the dwell counter: must hold 0..dwell_cycles without wrapping.
  function automatic int dwell_cnt_width(input int dwell_cycles);
    return (dwell_cycles < 1) ? 1 : $clog2(dwell_cycles + 1);
  endfunction

endpackage

// File: rtl/elevator_call_scheduler_floor_scan_pick.sv
// Combinational SCAN selection: nearest pending call above and below the car,
// plus whether the car's own floor has a pending call.
module floor_scan_pick #(
  parameter int NUM_FLOORS = 10,
  parameter int FLOOR_W    = elevator_call_scheduler_pkg::FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic [FLOOR_W-1:0]    above,
  output logic                  above_vld,
  output logic [FLOOR_W-1:0]    below,
  output logic                  below_vld,
  output logic                  here
);

  logic [31:0] cf_ext;

  assign cf_ext = 32'(current_floor);

  // Scan every floor; descending loop leaves the lowest hit above,
  // ascending loop leaves the highest hit below.
  always_comb begin
    above     = '0;
    above_vld = 1'b0;
    below     = '0;
    below_vld = 1'b0;
    here      = 1'b0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      above     = (pending[i] && (32'(i) > cf_ext)) ? FLOOR_W'(i) : above;
      above_vld = above_vld | (pending[i] && (32'(i) > cf_ext));
    end
    for (int j = 0; j < NUM_FLOORS; j++) begin
      below     = (pending[j] && (32'(j) < cf_ext)) ? FLOOR_W'(j) : below;
      below_vld = below_vld | (pending[j] && (32'(j) < cf_ext));
      // An out-of-range car position never matches, so it has no "here".
      here      = here | (pending[j] && (32'(j) == cf_ext));
    end
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Elevator call scheduler: latches floor calls, runs a SCAN sweep, drives the
// car controller's requested floor and holds the door open at served floors.
module elevator_call_scheduler #(
  parameter int NUM_FLOORS   = 10,
  parameter int FLOOR_W      = elevator_call_scheduler_pkg::FLOOR_W,
  parameter int DWELL_CYCLES = 20000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  car_idle,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  target_valid,
  output logic                  dir_up,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  import elevator_call_scheduler_pkg::*;

  localparam int              CNT_W    = dwell_cnt_width(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  ecs_state_e              state_q, state_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [FLOOR_W-1:0]      target_q, target_d;
  logic                    tvalid_q, tvalid_d;
  logic                    dir_up_q, dir_up_d;
  logic                    door_q, door_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [FLOOR_W-1:0]      scan_above, scan_below;
  logic                    scan_above_vld, scan_below_vld, scan_here;
  logic [NUM_FLOORS-1:0]   cf_mask, set_mask, clr_mask;
  logic                    at_target, hold_tgt, dwell_entry;

  floor_scan_pick #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_scan (
    .pending       (pending_q),
    .current_floor (current_floor),
    .above         (scan_above),
    .above_vld     (scan_above_vld),
    .below         (scan_below),
    .below_vld     (scan_below_vld),
    .here          (scan_here)
  );

  assign at_target   = (current_floor == target_q);
  assign dwell_entry = (state_d == ST_DWELL) && (state_q != ST_DWELL);

  // One-hot mask of the car's current floor (all zero when out of range).
  always_comb begin
    cf_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      cf_mask[i] = (32'(current_floor) == 32'(i));
    end
  end

  // Pending calls: set from buttons, cleared on entry to the dwell at that floor.
  always_comb begin
    if (state_q == ST_DWELL) begin
      // Door already open here, so the button for this floor is not latched.
      set_mask = call_req & ~cf_mask;
    end else begin
      set_mask = call_req;
    end
    if (dwell_entry) begin
      clr_mask = cf_mask;
    end else begin
      clr_mask = '0;
    end
    // Clear is applied last so it wins over a same-cycle press.
    pending_d = (pending_q | set_mask) & ~clr_mask;
  end

  // Next-state logic and dwell counter.
  always_comb begin
    state_d  = state_q;
    hold_tgt = 1'b0;
    cnt_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (scan_here) begin
          state_d = ST_DWELL;
        end else if (scan_above_vld) begin
          state_d = ST_SERVE_UP;
        end else if (scan_below_vld) begin
          state_d = ST_SERVE_DOWN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVE_UP: begin
        if (at_target && car_idle) begin
          state_d = ST_DWELL;
        end else if (at_target) begin
          // Car is at the target but still settling: keep the request stable.
          state_d  = ST_SERVE_UP;
          hold_tgt = 1'b1;
        end else if (scan_above_vld) begin
          state_d = ST_SERVE_UP;
        end else if (scan_below_vld) begin
          state_d = ST_SERVE_DOWN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVE_DOWN: begin
        if (at_target && car_idle) begin
          state_d = ST_DWELL;
        end else if (at_target) begin
          state_d  = ST_SERVE_DOWN;
          hold_tgt = 1'b1;
        end else if (scan_below_vld) begin
          state_d = ST_SERVE_DOWN;
        end else if (scan_above_vld) begin
          state_d = ST_SERVE_UP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DWELL: begin
        if (cnt_q == CNT_LAST) begin
          if (dir_up_q && scan_above_vld) begin
            state_d = ST_SERVE_UP;
          end else if (!dir_up_q && scan_below_vld) begin
            state_d = ST_SERVE_DOWN;
          end else if (scan_above_vld) begin
            state_d = ST_SERVE_UP;
          end else if (scan_below_vld) begin
            state_d = ST_SERVE_DOWN;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_DWELL;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the next state.
  always_comb begin
    target_d = current_floor;
    tvalid_d = 1'b0;
    dir_up_d = dir_up_q;
    door_d   = 1'b0;
    case (state_d)
      ST_IDLE: begin
        target_d = current_floor;
      end
      ST_SERVE_UP: begin
        tvalid_d = 1'b1;
        dir_up_d = 1'b1;
        target_d = hold_tgt ? target_q : scan_above;
      end
      ST_SERVE_DOWN: begin
        tvalid_d = 1'b1;
        dir_up_d = 1'b0;
        target_d = hold_tgt ? target_q : scan_below;
      end
      ST_DWELL: begin
        door_d   = 1'b1;
        target_d = current_floor;
      end
      default: begin
        target_d = current_floor;
      end
    endcase
  end

  // State, pending calls, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      target_q  <= '0;
      tvalid_q  <= 1'b0;
      dir_up_q  <= 1'b1;
      door_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      target_q  <= target_d;
      tvalid_q  <= tvalid_d;
      dir_up_q  <= dir_up_d;
      door_q    <= door_d;
      cnt_q     <= cnt_d;
    end
  end

  assign target_floor = target_q;
  assign target_valid = tvalid_q;
  assign dir_up       = dir_up_q;
  assign door_open    = door_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler with a simple car model
// (one floor per 3 cycles) and a 4-cycle dwell.
module tb_elevator_call_scheduler;

  localparam int NF = 10;
  localparam int FW = 4;

  logic          clk;
  logic          reset;
  logic [NF-1:0] call_req;
  logic [FW-1:0] car_floor;
  logic          car_idle;
  logic [FW-1:0] target_floor;
  logic          target_valid;
  logic          dir_up;
  logic          door_open;
  logic [NF-1:0] pending;
  logic [1:0]    mv_cnt;

  int checks;
  int failures;

  elevator_call_scheduler #(
    .NUM_FLOORS   (NF),
    .FLOOR_W      (FW),
    .DWELL_CYCLES (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .call_req      (call_req),
    .current_floor (car_floor),
    .car_idle      (car_idle),
    .target_floor  (target_floor),
    .target_valid  (target_valid),
    .dir_up        (dir_up),
    .door_open     (door_open),
    .pending       (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Car model: steps one floor toward a valid target every 3 cycles.
  assign car_idle = !(target_valid && (target_floor != car_floor));

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      car_floor <= 4'd0;
      mv_cnt    <= 2'd0;
    end else if (!car_idle) begin
      if (mv_cnt == 2'd2) begin
        mv_cnt    <= 2'd0;
        car_floor <= (target_floor > car_floor) ? car_floor + 4'd1 : car_floor - 4'd1;
      end else begin
        mv_cnt <= mv_cnt + 2'd1;
      end
    end else begin
      mv_cnt <= 2'd0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    call_req = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive a one-cycle button pulse; returns at the negedge after the sampling edge.
  task automatic press(input logic [NF-1:0] mask);
    call_req = mask;
    @(negedge clk);
    call_req = '0;
  endtask

  task automatic wait_door_open(input string tag);
    for (int k = 0; k < 200 && !door_open; k++) @(negedge clk);
    check(tag, 32'(door_open), 32'd1);
  endtask

  task automatic wait_door_close(input string tag);
    for (int k = 0; k < 50 && door_open; k++) @(negedge clk);
    check(tag, 32'(door_open), 32'd0);
  endtask

  int n;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    call_req = '0;
    repeat (2) @(negedge clk);

    // 1. Reset state
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_tvalid", 32'(target_valid), 32'd0);
    check("rst_dir", 32'(dir_up), 32'd1);
    check("rst_door", 32'(door_open), 32'd0);
    check("rst_target", 32'(target_floor), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 2. Single call to floor 5
    press(10'h020);
    check("t2_pending", 32'(pending), 32'h020);
    @(negedge clk);
    check("t2_target", 32'(target_floor), 32'd5);
    check("t2_tvalid", 32'(target_valid), 32'd1);
    check("t2_dir", 32'(dir_up), 32'd1);
    check("t2_state", 32'(dut.state_q), 32'd2);
    wait_door_open("t2_door_open");
    check("t2_door_floor", 32'(car_floor), 32'd5);
    n = 0;
    while (door_open && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("t2_dwell_len", 32'(n), 32'd4);
    check("t2_pending_clr", 32'(pending), 32'd0);
    check("t2_idle", 32'(dut.state_q), 32'd0);
    check("t2_tvalid_off", 32'(target_valid), 32'd0);
    check("t2_idle_target", 32'(target_floor), 32'd5);

    // 3. Calls 6 and 2 together from floor 0
    do_reset();
    press(10'h044);
    check("t3_pending", 32'(pending), 32'h044);
    @(negedge clk);
    check("t3_target2", 32'(target_floor), 32'd2);
    wait_door_open("t3_door2");
    check("t3_at2", 32'(target_floor), 32'd2);
    check("t3_pending6", 32'(pending), 32'h040);
    wait_door_close("t3_close2");
    check("t3_target6", 32'(target_floor), 32'd6);
    check("t3_dir_up", 32'(dir_up), 32'd1);
    check("t3_tvalid6", 32'(target_valid), 32'd1);
    wait_door_open("t3_door6");
    check("t3_at6", 32'(target_floor), 32'd6);
    wait_door_close("t3_close6");
    check("t3_idle", 32'(dut.state_q), 32'd0);
    check("t3_no_reverse", 32'(dir_up), 32'd1);

    // 4. Retarget mid-sweep, call behind the car waits for reversal
    do_reset();
    press(10'h080);
    @(negedge clk);
    check("t4_target7", 32'(target_floor), 32'd7);
    for (int k = 0; k < 100 && car_floor != 4'd3; k++) @(negedge clk);
    check("t4_reach3", 32'(car_floor), 32'd3);
    press(10'h020);
    @(negedge clk);
    check("t4_retarget5", 32'(target_floor), 32'd5);
    wait_door_open("t4_door5");
    check("t4_at5", 32'(target_floor), 32'd5);
    check("t4_pending7", 32'(pending), 32'h080);
    press(10'h002);
    wait_door_close("t4_close5");
    check("t4_target7b", 32'(target_floor), 32'd7);
    check("t4_dir_up7", 32'(dir_up), 32'd1);
    check("t4_pending71", 32'(pending), 32'h082);
    wait_door_open("t4_door7");
    check("t4_at7", 32'(target_floor), 32'd7);
    wait_door_close("t4_close7");
    check("t4_target1", 32'(target_floor), 32'd1);
    check("t4_dir_down", 32'(dir_up), 32'd0);
    check("t4_state_down", 32'(dut.state_q), 32'd3);
    wait_door_open("t4_door1");
    check("t4_at1", 32'(car_floor), 32'd1);
    wait_door_close("t4_close1");
    check("t4_idle", 32'(dut.state_q), 32'd0);
    check("t4_dir_kept", 32'(dir_up), 32'd0);
    check("t4_pending_empty", 32'(pending), 32'd0);

    // 5. Call at the current floor while idle, re-press during dwell
    do_reset();
    press(10'h001);
    check("t5_pending", 32'(pending), 32'h001);
    @(negedge clk);
    check("t5_dwell", 32'(dut.state_q), 32'd1);
    check("t5_door", 32'(door_open), 32'd1);
    check("t5_tvalid", 32'(target_valid), 32'd0);
    check("t5_pending_clr", 32'(pending), 32'd0);
    call_req = 10'h001;
    @(negedge clk);
    @(negedge clk);
    call_req = '0;
    check("t5_repress_ignored", 32'(pending), 32'd0);
    check("t5_still_dwell", 32'(door_open), 32'd1);
    wait_door_close("t5_close");
    check("t5_idle", 32'(dut.state_q), 32'd0);
    check("t5_pending_end", 32'(pending), 32'd0);

    // 6. Reset during SERVE_UP with three calls pending
    do_reset();
    press(10'h150);
    check("t6_pending", 32'(pending), 32'h150);
    @(negedge clk);
    check("t6_serve_up", 32'(dut.state_q), 32'd2);
    check("t6_target4", 32'(target_floor), 32'd4);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_rst_pending", 32'(pending), 32'd0);
    check("t6_rst_door", 32'(door_open), 32'd0);
    check("t6_rst_tvalid", 32'(target_valid), 32'd0);
    check("t6_rst_state", 32'(dut.state_q), 32'd0);
    check("t6_rst_target", 32'(target_floor), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    press(10'h004);
    @(negedge clk);
    check("t6_target2", 32'(target_floor), 32'd2);
    check("t6_tvalid2", 32'(target_valid), 32'd1);
    wait_door_open("t6_door2");
    check("t6_at2", 32'(car_floor), 32'd2);
    reset = 1'b1;
    #1;
    check("t6_rst_door_drop", 32'(door_open), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
